// File: rtl/arbitro_acceso_if.sv
// Signal bundle between the access arbiter, keypads A/B and the shared PIN checker.
interface arbitro_acceso_if;
    // keypad side
    logic       sol_a;
    logic       sol_b;
    logic       stb_a;
    logic       stb_b;
    logic [3:0] dig_a;
    logic [3:0] dig_b;
    // PIN checker side
    logic       me_aceptado;
    logic       me_denegado;
    logic       me_solicitud;
    logic       me_stb;
    logic [3:0] me_digito;
    logic       me_aborto;
    // per-requester status
    logic       gnt_a;
    logic       gnt_b;
    logic       aceptado_a;
    logic       aceptado_b;
    logic       denegado_a;
    logic       denegado_b;
    logic       bloqueo_a;
    logic       bloqueo_b;

    // Arbiter view
    modport slave (
        input  sol_a, sol_b, stb_a, stb_b, dig_a, dig_b, me_aceptado, me_denegado,
        output me_solicitud, me_stb, me_digito, me_aborto,
        output gnt_a, gnt_b, aceptado_a, aceptado_b, denegado_a, denegado_b,
        output bloqueo_a, bloqueo_b
    );

    // Environment view (keypads + PIN checker)
    modport master (
        output sol_a, sol_b, stb_a, stb_b, dig_a, dig_b, me_aceptado, me_denegado,
        input  me_solicitud, me_stb, me_digito, me_aborto,
        input  gnt_a, gnt_b, aceptado_a, aceptado_b, denegado_a, denegado_b,
        input  bloqueo_a, bloqueo_b
    );
endinterface

// File: rtl/arbitro_acceso.sv
// Two-keypad access arbiter in front of a single PIN checker: round-robin grant,
// digit forwarding, session timeout, per-keypad failure counting and lockout.
module arbitro_acceso #(
    parameter int TIMEOUT    = 64,
    parameter int MAX_FALLOS = 3,
    parameter int T_BLOQUEO  = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    arbitro_acceso_if.slave  bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT  = 2'd1;
    localparam logic [1:0] FWD    = 2'd2;
    localparam logic [1:0] RESULT = 2'd3;

    localparam int SES_W = $clog2(TIMEOUT + 1);
    localparam int FAL_W = $clog2(MAX_FALLOS + 1);
    localparam int BLQ_W = $clog2(T_BLOQUEO + 1);

    logic [1:0]       st;
    logic [1:0]       st_nxt;
    logic             owner_b;    // 1: B owns the current session
    logic             prio_b;     // 1: B wins a tie (A was served last)
    logic             res_ok;     // latched verdict for the RESULT cycle
    logic             res_abort;  // verdict came from the session timeout
    logic [SES_W-1:0] sess_cnt;
    logic [FAL_W-1:0] fail_a;
    logic [FAL_W-1:0] fail_b;
    logic [BLQ_W-1:0] lock_a;
    logic [BLQ_W-1:0] lock_b;
    logic             stb_q;
    logic [3:0]       dig_q;

    logic eleg_a;
    logic eleg_b;
    logic pick_b;
    logic me_res;
    logic timeout_hit;

    assign eleg_a      = bus.sol_a & (lock_a == '0);
    assign eleg_b      = bus.sol_b & (lock_b == '0);
    assign pick_b      = eleg_b & (~eleg_a | prio_b);
    assign me_res      = bus.me_aceptado | bus.me_denegado;
    assign timeout_hit = (sess_cnt == SES_W'(TIMEOUT - 1));

    // Next-state selection for the session FSM.
    always_comb begin
        // NOTE: default assignment first so no path leaves st_nxt unassigned (no latch).
        st_nxt = st;
        case (st)
            IDLE:    if (eleg_a | eleg_b) st_nxt = GRANT;
            GRANT:   st_nxt = FWD;
            FWD:     if (me_res | timeout_hit) st_nxt = RESULT;
            default: st_nxt = IDLE;
        endcase
    end

    // Session control: state, owner, tie pointer, session timer and verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            owner_b   <= 1'b0;
            prio_b    <= 1'b0;
            sess_cnt  <= '0;
            res_ok    <= 1'b0;
            res_abort <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            st <= st_nxt;
            case (st)
                IDLE: begin
                    if (eleg_a | eleg_b) owner_b <= pick_b;
                end
                GRANT: begin
                    sess_cnt <= '0;
                end
                FWD: begin
                    if (me_res) begin
                        // Both results together count as a denial.
                        res_ok    <= bus.me_aceptado & ~bus.me_denegado;
                        res_abort <= 1'b0;
                    end else if (timeout_hit) begin
                        res_ok    <= 1'b0;
                        res_abort <= 1'b1;
                    end else begin
                        sess_cnt <= sess_cnt + SES_W'(1);
                    end
                end
                default: begin
                    prio_b    <= ~owner_b;
                    res_abort <= 1'b0;
                end
            endcase
        end
    end

    // Failure tally and lockout countdown per keypad; countdowns run in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_a <= '0;
            fail_b <= '0;
            lock_a <= '0;
            lock_b <= '0;
        end else begin
            if (lock_a != '0) lock_a <= lock_a - BLQ_W'(1);
            if (lock_b != '0) lock_b <= lock_b - BLQ_W'(1);
            if (st == RESULT) begin
                if (!owner_b) begin
                    if (res_ok) begin
                        fail_a <= '0;
                    end else if (fail_a + FAL_W'(1) == FAL_W'(MAX_FALLOS)) begin
                        fail_a <= '0;
                        lock_a <= BLQ_W'(T_BLOQUEO);
                    end else begin
                        fail_a <= fail_a + FAL_W'(1);
                    end
                end else begin
                    if (res_ok) begin
                        fail_b <= '0;
                    end else if (fail_b + FAL_W'(1) == FAL_W'(MAX_FALLOS)) begin
                        fail_b <= '0;
                        lock_b <= BLQ_W'(T_BLOQUEO);
                    end else begin
                        fail_b <= fail_b + FAL_W'(1);
                    end
                end
            end
        end
    end

    // One-cycle delay of the owner's keypad strobe/digit toward the PIN checker.
    always_ff @(posedge clk) begin
        // NOTE: no reset on this data stage; its outputs are gated by the FWD state.
        stb_q <= owner_b ? bus.stb_b : bus.stb_a;
        dig_q <= owner_b ? bus.dig_b : bus.dig_a;
    end

    assign bus.gnt_a        = (st != IDLE) & ~owner_b;
    assign bus.gnt_b        = (st != IDLE) &  owner_b;
    assign bus.me_solicitud = (st == GRANT);
    assign bus.me_stb       = (st == FWD) & stb_q;
    assign bus.me_digito    = (st == FWD) ? dig_q : 4'd0;
    assign bus.me_aborto    = (st == RESULT) & res_abort;
    assign bus.aceptado_a   = (st == RESULT) & ~owner_b &  res_ok;
    assign bus.aceptado_b   = (st == RESULT) &  owner_b &  res_ok;
    assign bus.denegado_a   = (st == RESULT) & ~owner_b & ~res_ok;
    assign bus.denegado_b   = (st == RESULT) &  owner_b & ~res_ok;
    assign bus.bloqueo_a    = (lock_a != '0);
    assign bus.bloqueo_b    = (lock_b != '0);

endmodule

// File: tb/tb_arbitro_acceso.sv
// Self-checking bench for arbitro_acceso: directed vector tables, multi-cycle
// sequences and randomized traffic against a session-level reference model.
module tb_arbitro_acceso;

    localparam int TIMEOUT    = 64;
    localparam int MAX_FALLOS = 3;
    localparam int T_BLOQUEO  = 200;

    // Output vector layout used by every comparison.
    localparam logic [14:0] O_GNT_A = 15'h4000;
    localparam logic [14:0] O_GNT_B = 15'h2000;
    localparam logic [14:0] O_SOL   = 15'h1000;
    localparam logic [14:0] O_STB   = 15'h0800;
    localparam logic [14:0] O_ACC_A = 15'h0020;
    localparam logic [14:0] O_ACC_B = 15'h0010;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    arbitro_acceso_if bus();

    arbitro_acceso #(
        .TIMEOUT   (TIMEOUT),
        .MAX_FALLOS(MAX_FALLOS),
        .T_BLOQUEO (T_BLOQUEO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          sa, sb, ta, tb;
        bit [3:0]    da, db;
        bit          acc, den;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[$];

    // ---------------- reference model (session level) ----------------
    bit       m_busy;
    bit       m_closing;
    bit       m_ok;
    bit       m_abort;
    int       m_owner;
    int       m_age;      // cycles since the grant cycle of the session
    int       m_fwd;      // forwarding cycles used so far
    int       m_last;     // requester served last, -1 = none
    int       m_fails[2];
    int       m_lock[2];
    bit       m_prev_stb[2];
    bit [3:0] m_prev_dig[2];

    task automatic model_reset();
        m_busy = 0; m_closing = 0; m_ok = 0; m_abort = 0;
        m_owner = 0; m_age = 0; m_fwd = 0; m_last = -1;
        for (int r = 0; r < 2; r++) begin
            m_fails[r] = 0; m_lock[r] = 0; m_prev_stb[r] = 0; m_prev_dig[r] = 0;
        end
    endtask

    function automatic bit model_forwarding();
        return m_busy && m_age >= 1 && !m_closing;
    endfunction

    function automatic logic [14:0] model_out();
        logic [14:0] o;
        bit fw;
        o  = '0;
        fw = model_forwarding();
        o[14]   = m_busy && m_owner == 0;
        o[13]   = m_busy && m_owner == 1;
        o[12]   = m_busy && m_age == 0;
        o[11]   = fw && m_prev_stb[m_owner];
        o[10:7] = fw ? m_prev_dig[m_owner] : 4'd0;
        o[6]    = m_closing && m_abort;
        o[5]    = m_closing && m_owner == 0 &&  m_ok;
        o[4]    = m_closing && m_owner == 1 &&  m_ok;
        o[3]    = m_closing && m_owner == 0 && !m_ok;
        o[2]    = m_closing && m_owner == 1 && !m_ok;
        o[1]    = m_lock[0] > 0;
        o[0]    = m_lock[1] > 0;
        return o;
    endfunction

    // Advance the model across one rising edge using the inputs present at it.
    task automatic model_edge();
        bit sol[2], elig[2], stb[2];
        bit [3:0] dig[2];
        bit acc, den;
        int w;
        sol[0] = bus.sol_a; sol[1] = bus.sol_b;
        stb[0] = bus.stb_a; stb[1] = bus.stb_b;
        dig[0] = bus.dig_a; dig[1] = bus.dig_b;
        acc = bus.me_aceptado; den = bus.me_denegado;
        for (int r = 0; r < 2; r++) elig[r] = sol[r] && m_lock[r] == 0;
        for (int r = 0; r < 2; r++) if (m_lock[r] > 0) m_lock[r]--;
        if (!m_busy) begin
            if (elig[0] || elig[1]) begin
                if (elig[0] && elig[1]) w = (m_last == 0) ? 1 : 0;
                else                    w = elig[0] ? 0 : 1;
                m_busy = 1; m_owner = w; m_age = 0; m_closing = 0; m_fwd = 0;
            end
        end else if (m_closing) begin
            if (m_ok) m_fails[m_owner] = 0;
            else begin
                m_fails[m_owner]++;
                if (m_fails[m_owner] == MAX_FALLOS) begin
                    m_fails[m_owner] = 0;
                    m_lock[m_owner]  = T_BLOQUEO;
                end
            end
            m_last = m_owner; m_busy = 0; m_closing = 0;
        end else if (m_age == 0) begin
            m_age = 1;
        end else begin
            m_fwd++;
            if (acc || den) begin
                m_closing = 1; m_ok = acc && !den; m_abort = 0;
            end else if (m_fwd == TIMEOUT) begin
                m_closing = 1; m_ok = 0; m_abort = 1;
            end
        end
        m_prev_stb = stb;
        m_prev_dig = dig;
    endtask

    // ---------------- helpers ----------------
    function automatic logic [14:0] pack_dut();
        return {bus.gnt_a, bus.gnt_b, bus.me_solicitud, bus.me_stb, bus.me_digito,
                bus.me_aborto, bus.aceptado_a, bus.aceptado_b, bus.denegado_a,
                bus.denegado_b, bus.bloqueo_a, bus.bloqueo_b};
    endfunction

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit sa, input bit sb, input bit ta, input bit tb,
                         input bit [3:0] da, input bit [3:0] db, input bit acc, input bit den);
        bus.sol_a = sa; bus.sol_b = sb; bus.stb_a = ta; bus.stb_b = tb;
        bus.dig_a = da; bus.dig_b = db; bus.me_aceptado = acc; bus.me_denegado = den;
    endtask

    // One clock: model and DUT both cross the edge, outputs compared 1 ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model", pack_dut(), model_out());
    endtask

    // Asynchronous reset mid-cycle, held over two edges, released before the next edge.
    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check({tag, "_async"}, pack_dut(), 15'd0);
        model_reset();
        repeat (2) begin
            @(posedge clk);
            #1 check({tag, "_held"}, pack_dut(), 15'd0);
        end
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(bit sa, bit sb, bit ta, bit tb, bit [3:0] da, bit [3:0] db,
                                bit acc, bit den, logic [14:0] exp);
        vec_t v;
        v.sa = sa; v.sb = sb; v.ta = ta; v.tb = tb; v.da = da; v.db = db;
        v.acc = acc; v.den = den; v.exp = exp;
        return v;
    endfunction

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].sa, vecs[i].sb, vecs[i].ta, vecs[i].tb,
                  vecs[i].da, vecs[i].db, vecs[i].acc, vecs[i].den);
            step();
            check($sformatf("%s_row%0d", tag, i), pack_dut(), vecs[i].exp);
        end
        vecs.delete();
    endtask

    int n_den_a;
    int n_acc_a;

    // Request, wait for forwarding, answer with the given result, return to idle.
    task automatic serve(input bit sa, input bit sb, input bit acc, input bit den, input string tag);
        int reached;
        reached = 0;
        drive(sa, sb, 0, 0, 4'd0, 4'd0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step();
            if (model_forwarding()) begin reached = 1; break; end
        end
        check_int({tag, "_fwd_reached"}, reached, 1);
        drive(0, 0, 0, 0, 4'd0, 4'd0, acc, den);
        step();
        if (bus.denegado_a) n_den_a++;
        if (bus.aceptado_a) n_acc_a++;
        drive(0, 0, 0, 0, 4'd0, 4'd0, 0, 0);
        step();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int blq, gnt_a_seen, b_acc, a_back, abort_idx, den_seen;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 4'd0, 4'd0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        do_reset("init");

        // A enters 6,9,6,9 and is accepted; B's keypad activity is ignored.
        vecs.push_back(mk(1, 0, 0, 0, 4'd0, 4'd0, 0, 0, O_GNT_A | O_SOL));
        vecs.push_back(mk(1, 0, 1, 0, 4'd6, 4'd0, 0, 0, O_GNT_A | O_STB | (15'd6 << 7)));
        vecs.push_back(mk(1, 0, 1, 1, 4'd9, 4'd3, 0, 0, O_GNT_A | O_STB | (15'd9 << 7)));
        vecs.push_back(mk(1, 0, 1, 0, 4'd6, 4'd0, 0, 0, O_GNT_A | O_STB | (15'd6 << 7)));
        vecs.push_back(mk(1, 0, 1, 0, 4'd9, 4'd0, 0, 0, O_GNT_A | O_STB | (15'd9 << 7)));
        vecs.push_back(mk(1, 0, 0, 0, 4'd0, 4'd0, 1, 0, O_GNT_A | O_ACC_A));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 15'd0));
        vecs.push_back(mk(0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 15'd0));
        run_vecs("pin_a");

        // Simultaneous requests after reset: A, then B, then A again.
        do_reset("rr");
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 4'd0, 0, 0, O_GNT_A | O_SOL));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 4'd0, 0, 0, O_GNT_A));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 4'd0, 1, 0, O_GNT_A | O_ACC_A));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 4'd0, 0, 0, 15'd0));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 4'd0, 0, 0, O_GNT_B | O_SOL));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 4'd0, 0, 0, O_GNT_B));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 4'd0, 1, 0, O_GNT_B | O_ACC_B));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 4'd0, 0, 0, 15'd0));
        vecs.push_back(mk(1, 1, 0, 0, 4'd0, 4'd0, 0, 0, O_GNT_A | O_SOL));
        run_vecs("rr");

        // Timeout: SOL_A dropped after the grant, checker never answers.
        do_reset("to");
        drive(1, 0, 0, 0, 4'd0, 4'd0, 0, 0);
        step();
        drive(0, 0, 0, 0, 4'd0, 4'd0, 0, 0);
        abort_idx = -1;
        den_seen  = 0;
        for (int idx = 2; idx < TIMEOUT + 10; idx++) begin
            step();
            if (bus.me_aborto) begin
                abort_idx = idx;
                den_seen  = bus.denegado_a;
                break;
            end
        end
        check_int("timeout_cycle", abort_idx, TIMEOUT + 2);
        check_int("timeout_den_a", den_seen, 1);
        step();
        check("timeout_idle", pack_dut(), 15'd0);

        // Three denials for A (the second with both results high) lock A out.
        do_reset("lock");
        n_den_a = 0;
        n_acc_a = 0;
        serve(1, 0, 0, 1, "den1");
        serve(1, 0, 1, 1, "den2_both");
        serve(1, 0, 0, 1, "den3");
        check_int("den_a_pulses", n_den_a, 3);
        check_int("acc_a_pulses", n_acc_a, 0);
        check_int("bloqueo_a_on", int'(bus.bloqueo_a), 1);
        blq        = bus.bloqueo_a ? 1 : 0;
        gnt_a_seen = 0;
        b_acc      = 0;
        for (int i = 0; i < T_BLOQUEO + 20 && bus.bloqueo_a; i++) begin
            drive(1, 1, 0, 0, 4'd0, 4'd0, model_forwarding(), 0);
            step();
            if (bus.bloqueo_a)  blq++;
            if (bus.gnt_a)      gnt_a_seen++;
            if (bus.aceptado_b) b_acc++;
        end
        check_int("lock_length", blq, T_BLOQUEO);
        check_int("locked_a_grants", gnt_a_seen, 0);
        check_int("b_served_during_lock", int'(b_acc > 0), 1);
        a_back = 0;
        for (int i = 0; i < 12 && !a_back; i++) begin
            drive(1, 1, 0, 0, 4'd0, 4'd0, model_forwarding(), 0);
            step();
            if (bus.gnt_a) a_back = 1;
        end
        check_int("a_after_lock", a_back, 1);

        // Reset in the middle of forwarding with a result pending.
        do_reset("pre_mid");
        drive(1, 0, 0, 0, 4'd0, 4'd0, 0, 0);
        step();
        drive(1, 0, 1, 0, 4'd5, 4'd0, 0, 0);
        step();
        step();
        drive(1, 0, 0, 0, 4'd0, 4'd0, 1, 0);
        do_reset("mid");
        drive(1, 0, 0, 0, 4'd0, 4'd0, 0, 0);
        step();
        check("mid_regrant", pack_dut(), O_GNT_A | O_SOL);

        // Randomized traffic against the model.
        do_reset("rnd");
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset("rnd2");
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/arbitro_acceso.md
ARBITRO_ACCESO -- requirements
Module: arbitro_acceso

Interface
REQ-001 Parameter TIMEOUT, 64, max cycles in session without a PIN-checker result.
REQ-002 Parameter MAX_FALLOS, 3, consecutive failures per requester that trigger lockout.
REQ-003 Parameter T_BLOQUEO, 200, lockout duration in cycles.
REQ-004 CLK  input  1  single clock; all state on rising edge.
REQ-005 RESET  input  1  asynchronous, active-low reset.
REQ-006 SOL_A, SOL_B  input  1 each  access request, level, from keypad A / B.
REQ-007 STB_A, STB_B  input  1 each  digit strobe from keypad A / B.
REQ-008 DIG_A, DIG_B  input  4 each  digit value from keypad A / B.
REQ-009 ME_ACEPTADO, ME_DENEGADO  input  1 each  result from the shared PIN checker.
REQ-010 ME_SOLICITUD  output  1  access request to the PIN checker.
REQ-011 ME_STB, ME_DIGITO  output  1 / 4  forwarded strobe and digit to the PIN checker.
REQ-012 ME_ABORTO  output  1  one-cycle pulse forcing the PIN checker back to idle.
REQ-013 GNT_A, GNT_B  output  1 each  requester currently owns the checker.
REQ-014 ACEPTADO_A/B, DENEGADO_A/B  output  1 each  one-cycle result pulse per requester.
REQ-015 BLOQUEO_A, BLOQUEO_B  output  1 each  requester locked out.

Function
REQ-016 FSM states SHALL be IDLE, GRANT, FWD, RESULT.
REQ-017 IDLE: eligible requester = SOL_x high and BLOQUEO_x low; if any, go GRANT next edge.
REQ-018 Arbitration: single eligible requester wins; both eligible -> the one not served last; pointer resets to favour A.
REQ-019 GRANT: exactly one cycle; GNT_x high, ME_SOLICITUD high; then FWD.
REQ-020 GNT_x SHALL stay high from GRANT through RESULT; never both GNT high.
REQ-021 FWD: ME_STB/ME_DIGITO = granted requester's STB/DIG registered one cycle (latency 1); non-granted inputs ignored; ME_STB=0 and ME_DIGITO=0 outside FWD.
REQ-022 FWD exit: ME_ACEPTADO or ME_DENEGADO high -> RESULT; both high same cycle -> treated as denial.
REQ-023 FWD timeout: session counter reaching TIMEOUT without result -> denial, ME_ABORTO pulsed one cycle, go RESULT.
REQ-024 RESULT: one cycle; pulse ACEPTADO_x or DENEGADO_x for granted requester; update pointer; then IDLE.
REQ-025 SOL_x dropping during a session SHALL NOT abort it; session ends only by result or timeout.
REQ-026 Acceptance clears that requester's fail counter; denial increments it.
REQ-027 Counter reaching MAX_FALLOS: BLOQUEO_x high from next cycle for exactly T_BLOQUEO cycles, counter cleared.
REQ-028 Locked requester's SOL ignored; other requester served normally; lockout counters run in every state.
REQ-029 Counter widths SHALL hold the parameter values without wrap; no counter wraps past its limit.

Reset
REQ-030 RESET low SHALL immediately force IDLE, all outputs 0, fail/lockout/session counters 0, pointer favouring A.
REQ-031 RESET low mid-session SHALL NOT produce a result pulse or ME_ABORTO.
REQ-032 First grant no earlier than the first rising edge after RESET deasserts.

Verification
REQ-033 SOL_A=1, digits 6,9,6,9, ME_ACEPTADO pulse -> ACEPTADO_A one cycle, GNT_A low after RESULT, fail A=0.
REQ-034 SOL_A=SOL_B=1 same cycle after reset -> GNT_A first; after A's result, GNT_B; then A again if both still requesting.
REQ-035 Three consecutive ME_DENEGADO for A -> three DENEGADO_A pulses, BLOQUEO_A high 200 cycles; B granted meanwhile; A ignored until BLOQUEO_A falls.
REQ-036 Grant A, no ME result for 64 cycles -> ME_ABORTO and DENEGADO_A pulse same RESULT entry, back to IDLE.
REQ-037 ME_ACEPTADO and ME_DENEGADO high together -> DENEGADO_x only, fail counter incremented.
REQ-038 RESET low during FWD -> all outputs 0 same cycle, no result pulse, normal grant after release.
